// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared types and constants for the memory access checker:
//   - size_e           : access size encoding (byte/half/word, 3 illegal)
//   - PERM_R/W/SUB     : bit positions inside a 3-bit {SUB,W,R} permission
//   - EXC_ADEL/ADES    : address-error exception codes (load / store)
//   - DEF_BASE/LIMIT/PERM and def_*() : region table reset contents;
//     entries past the default list reset to base=1, limit=0 (never match).
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    localparam int PERM_R   = 0;
    localparam int PERM_W   = 1;
    localparam int PERM_SUB = 2;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int DEF_REGIONS = 6;

    localparam logic [31:0] DEF_BASE [DEF_REGIONS] = '{
        32'h0000_0000, 32'h0000_7F00, 32'h0000_7F08,
        32'h0000_7F10, 32'h0000_7F18, 32'h0000_7F20
    };

    localparam logic [31:0] DEF_LIMIT [DEF_REGIONS] = '{
        32'h0000_2FFF, 32'h0000_7F07, 32'h0000_7F0B,
        32'h0000_7F17, 32'h0000_7F1B, 32'h0000_7F23
    };

    // {SUB,W,R}: RWS, RW, R, RW, R, RWS
    localparam logic [2:0] DEF_PERM [DEF_REGIONS] = '{
        3'b111, 3'b011, 3'b001, 3'b011, 3'b001, 3'b111
    };

    function automatic logic [31:0] def_base(input int idx);
        return (idx < DEF_REGIONS) ? DEF_BASE[idx] : 32'h0000_0001;
    endfunction

    function automatic logic [31:0] def_limit(input int idx);
        return (idx < DEF_REGIONS) ? DEF_LIMIT[idx] : 32'h0000_0000;
    endfunction

    function automatic logic [2:0] def_perm(input int idx);
        return (idx < DEF_REGIONS) ? DEF_PERM[idx] : 3'b000;
    endfunction

    // Byte count of an access; the illegal size is faulted elsewhere, so its
    // count only has to be harmless.
    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_checker_if.sv
// ---------------------------------------------------------------------------
// mem_access_checker_if
// Bundles the region-table config port, the M-stage request, pipeline
// control and the registered CP0-facing result of mem_access_checker.
//   master : drives cfg_*, req_*, exc_in/exc_code_in, stall, flush, exc_ack
//   slave  : the checker; drives exc_out, exc_code_out, bad_vaddr, bad_pend
// Optional macro MAC_ADDR_OVF_EN adds the addr_ovf request input.
// ---------------------------------------------------------------------------
interface mem_access_checker_if #(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGIONS = 6
);
    import mac_pkg::*;

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_limit;
    logic [2:0]        cfg_perm;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    size_e             req_size;
    logic              req_store;
`ifdef MAC_ADDR_OVF_EN
    logic              addr_ovf;
`endif

    logic              exc_in;
    logic [4:0]        exc_code_in;
    logic              stall;
    logic              flush;
    logic              exc_ack;

    logic              exc_out;
    logic [4:0]        exc_code_out;
    logic [ADDR_W-1:0] bad_vaddr;
    logic              bad_pend;

    modport master (
`ifdef MAC_ADDR_OVF_EN
        output addr_ovf,
`endif
        output cfg_we, cfg_idx, cfg_base, cfg_limit, cfg_perm,
        output req_valid, req_addr, req_size, req_store,
        output exc_in, exc_code_in, stall, flush, exc_ack,
        input  exc_out, exc_code_out, bad_vaddr, bad_pend
    );

    modport slave (
`ifdef MAC_ADDR_OVF_EN
        input  addr_ovf,
`endif
        input  cfg_we, cfg_idx, cfg_base, cfg_limit, cfg_perm,
        input  req_valid, req_addr, req_size, req_store,
        input  exc_in, exc_code_in, stall, flush, exc_ack,
        output exc_out, exc_code_out, bad_vaddr, bad_pend
    );

endinterface

// File: rtl/mac_region_match.sv
// ---------------------------------------------------------------------------
// mac_region_match
// Compares one access against one region table entry.
//   addr, bytes     : access start address and byte count (1/2/4)
//   base, limit     : inclusive region bounds
//   perm            : {SUB,W,R} permission bits of the region
//   is_store/is_sub : access is a store / a byte-or-half access
//   hit             : whole access lies inside [base, limit]
//   allow           : region permissions permit this access
// ---------------------------------------------------------------------------
module mac_region_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        bytes,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    input  logic [2:0]        perm,
    input  logic              is_store,
    input  logic              is_sub,
    output logic              hit,
    output logic              allow
);
    import mac_pkg::*;

    // Last byte touched, one bit wider than the address so an access that
    // wraps past the top of the address space compares above every limit.
    logic [ADDR_W:0] last;

    assign last  = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, bytes}
                 - {{ADDR_W{1'b0}}, 1'b1};
    assign hit   = (base <= addr) && (last <= {1'b0, limit});
    assign allow = (is_store ? perm[PERM_W] : perm[PERM_R])
                && (!is_sub || perm[PERM_SUB]);

endmodule

// File: rtl/mem_access_checker.sv
// ---------------------------------------------------------------------------
// mem_access_checker
// M-stage address-exception checker. Each load/store address is checked for
// legal size, natural alignment, containment in a programmable region table
// (lowest matching index wins) and that region's permissions. The result is
// registered once toward CP0; the first local fault address is held in a
// sticky BadVAddr until CP0 acknowledges it.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (also restores table)
//   bus        : mem_access_checker_if.slave (config, request, control,
//                exc_out/exc_code_out/bad_vaddr/bad_pend results)
// Optional macro MAC_ADDR_OVF_EN: adds bus.addr_ovf; an ALU overflow on a
// valid request without an upstream exception raises an address error
// ahead of all other local checks.
// ---------------------------------------------------------------------------
module mem_access_checker #(
    parameter int         NUM_REGIONS = 6,
    parameter int         ADDR_W      = 32,
    parameter logic [4:0] EXC_ADEL    = 5'd4,
    parameter logic [4:0] EXC_ADES    = 5'd5
) (
    input logic                 clk,
    input logic                 reset,
    mem_access_checker_if.slave bus
);
    import mac_pkg::size_e;
    import mac_pkg::SIZE_BYTE;
    import mac_pkg::SIZE_HALF;
    import mac_pkg::SIZE_WORD;
    import mac_pkg::SIZE_BAD;
    import mac_pkg::size_bytes;
    import mac_pkg::def_base;
    import mac_pkg::def_limit;
    import mac_pkg::def_perm;

    // ---------------- region table ----------------
    logic [ADDR_W-1:0] base_q  [NUM_REGIONS];
    logic [ADDR_W-1:0] limit_q [NUM_REGIONS];
    logic [2:0]        perm_q  [NUM_REGIONS];

    // NOTE: the table is a register file that must come out of reset with
    // usable defaults, so every entry sits on the async reset; a plain RAM
    // without reset would leave the checker faulting every access.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values and a request in the same cycle as a
    // config write is still checked against the old table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i]  <= ADDR_W'(def_base(i));
                limit_q[i] <= ADDR_W'(def_limit(i));
                perm_q[i]  <= def_perm(i);
            end
        end else begin
            // An index at or past NUM_REGIONS matches no entry and is dropped.
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (bus.cfg_we && (int'(bus.cfg_idx) == i)) begin
                    base_q[i]  <= bus.cfg_base;
                    limit_q[i] <= bus.cfg_limit;
                    perm_q[i]  <= bus.cfg_perm;
                end
            end
        end
    end

    // ---------------- per-region compare ----------------
    logic [2:0]             req_bytes;
    logic                   req_is_sub;
    logic [NUM_REGIONS-1:0] hit;
    logic [NUM_REGIONS-1:0] allow;

    assign req_bytes  = size_bytes(bus.req_size);
    assign req_is_sub = (bus.req_size == SIZE_BYTE) || (bus.req_size == SIZE_HALF);

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        mac_region_match #(
            .ADDR_W (ADDR_W)
        ) u_match (
            .addr     (bus.req_addr),
            .bytes    (req_bytes),
            .base     (base_q[g]),
            .limit    (limit_q[g]),
            .perm     (perm_q[g]),
            .is_store (bus.req_store),
            .is_sub   (req_is_sub),
            .hit      (hit[g]),
            .allow    (allow[g])
        );
    end

    // ---------------- priority pick ----------------
    logic any_hit;
    logic sel_allow;

    // NOTE: every always_comb output gets a default before any branch so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        any_hit   = 1'b0;
        sel_allow = 1'b0;
        // Scan downward so the lowest-index hit is the last one written.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit   = 1'b1;
                sel_allow = allow[i];
            end
        end
    end

    // ---------------- fault evaluation ----------------
    logic addr_ovf;
`ifdef MAC_ADDR_OVF_EN
    assign addr_ovf = bus.addr_ovf;
`else
    assign addr_ovf = 1'b0;
`endif

    logic       misalign;
    logic       local_fault;
    logic       nxt_exc;
    logic [4:0] nxt_code;

    always_comb begin
        misalign = ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
                || ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));

        // All local checks yield the same code, so their priority order only
        // matters conceptually; an OR of the conditions is equivalent.
        local_fault = bus.req_valid && !bus.exc_in
                   && (addr_ovf || (bus.req_size == SIZE_BAD) || misalign
                       || !any_hit || !sel_allow);

        nxt_exc  = 1'b0;
        nxt_code = 5'd0;
        if (bus.req_valid) begin
            if (bus.exc_in) begin
                nxt_exc  = 1'b1;
                nxt_code = bus.exc_code_in;
            end else if (local_fault) begin
                nxt_exc  = 1'b1;
                nxt_code = bus.req_store ? EXC_ADES : EXC_ADEL;
            end
        end
    end

    // ---------------- output register and BadVAddr capture ----------------
    logic              exc_q;
    logic [4:0]        code_q;
    logic [ADDR_W-1:0] bad_vaddr_q;
    logic              bad_pend_q;
    logic              load_en;
    logic              capture;

    assign load_en = !bus.stall && !bus.flush;
    // An acknowledge in the same cycle frees the capture slot for this fault.
    assign capture = local_fault && load_en && (!bad_pend_q || bus.exc_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_q       <= 1'b0;
            code_q      <= 5'd0;
            bad_vaddr_q <= '0;
            bad_pend_q  <= 1'b0;
        end else begin
            if (!bus.stall) begin
                exc_q  <= bus.flush ? 1'b0 : nxt_exc;
                code_q <= bus.flush ? 5'd0 : nxt_code;
            end

            if (capture) begin
                bad_vaddr_q <= bus.req_addr;
                bad_pend_q  <= 1'b1;
            end else if (bus.exc_ack) begin
                bad_pend_q  <= 1'b0;
            end
        end
    end

    assign bus.exc_out      = exc_q;
    assign bus.exc_code_out = code_q;
    assign bus.bad_vaddr    = bad_vaddr_q;
    assign bus.bad_pend     = bad_pend_q;

endmodule

// File: tb/tb_mem_access_checker.sv
// ---------------------------------------------------------------------------
// tb_mem_access_checker
// Directed bench for mem_access_checker: a table of single-cycle requests
// with hand-computed results (run with exc_ack held high so every local
// fault re-captures), then hand sequences for sticky capture, stall/flush,
// same-cycle config writes and mid-run reset.
// ---------------------------------------------------------------------------
module tb_mem_access_checker;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_checker_if #(.ADDR_W(32), .NUM_REGIONS(6)) bus ();

    mem_access_checker #(
        .NUM_REGIONS (6),
        .ADDR_W      (32),
        .EXC_ADEL    (5'd4),
        .EXC_ADES    (5'd5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        size_e       size;
        logic        store;
        logic        exc_in;
        logic [4:0]  code_in;
        logic        exp_exc;
        logic [4:0]  exp_code;
        logic        exp_local;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic valid, input logic [31:0] addr, input size_e size,
                           input logic store, input logic exc_in, input logic [4:0] code_in,
                           input logic exp_exc, input logic [4:0] exp_code,
                           input logic exp_local);
        vec_t v;
        v.valid = valid; v.addr = addr; v.size = size; v.store = store;
        v.exc_in = exc_in; v.code_in = code_in;
        v.exp_exc = exp_exc; v.exp_code = exp_code; v.exp_local = exp_local;
        vecs.push_back(v);
    endtask

    task automatic idle();
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_base = '0;
        bus.cfg_limit = '0; bus.cfg_perm = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_size = SIZE_BYTE;
        bus.req_store = 1'b0; bus.exc_in = 1'b0; bus.exc_code_in = '0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.exc_ack = 1'b0;
`ifdef MAC_ADDR_OVF_EN
        bus.addr_ovf = 1'b0;
`endif
    endtask

    task automatic req(input logic [31:0] addr, input size_e size, input logic store);
        bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_size = size;
        bus.req_store = store; bus.exc_in = 1'b0; bus.exc_code_in = '0;
    endtask

    // Advance one edge and settle: inputs are driven and outputs sampled
    // 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic exc, input logic [4:0] code);
        check({tag, ".exc"}, 32'(bus.exc_out), 32'(exc));
        check({tag, ".code"}, 32'(bus.exc_code_out), 32'(code));
    endtask

    task automatic check_bad(input string tag, input logic pend, input logic [31:0] addr);
        check({tag, ".pend"}, 32'(bus.bad_pend), 32'(pend));
        check({tag, ".vaddr"}, bus.bad_vaddr, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // valid addr          size       st  ein code  exc code local
        add_vec(1, 32'h0000_2FFC, SIZE_WORD, 0, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_2FFE, SIZE_WORD, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_7F08, SIZE_WORD, 1, 0, 5'd0,  1, 5'd5,  1);
        add_vec(1, 32'h0000_7F00, SIZE_BYTE, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_7F20, SIZE_BYTE, 1, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_2FFF, SIZE_HALF, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'hFFFF_FFFC, SIZE_WORD, 1, 0, 5'd0,  1, 5'd5,  1);
        add_vec(1, 32'h0000_7F04, SIZE_WORD, 0, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_7F06, SIZE_HALF, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_7F0C, SIZE_WORD, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_0000, SIZE_BAD,  0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_0000, SIZE_BAD,  1, 0, 5'd0,  1, 5'd5,  1);
        add_vec(1, 32'h0000_1235, SIZE_WORD, 0, 1, 5'd12, 1, 5'd12, 0);
        add_vec(0, 32'h0000_2FFE, SIZE_WORD, 0, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_2FFE, SIZE_HALF, 1, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_7F18, SIZE_WORD, 1, 0, 5'd0,  1, 5'd5,  1);
        add_vec(1, 32'h0000_7F18, SIZE_WORD, 0, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_3000, SIZE_BYTE, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_7F20, SIZE_WORD, 1, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_7F23, SIZE_BYTE, 0, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_7F22, SIZE_HALF, 0, 0, 5'd0,  0, 5'd0,  0);
        add_vec(1, 32'h0000_7F24, SIZE_BYTE, 0, 0, 5'd0,  1, 5'd4,  1);
        add_vec(1, 32'h0000_7F14, SIZE_WORD, 1, 0, 5'd0,  0, 5'd0,  0);

        // ---------------- reset state ----------------
        idle();
        reset = 1'b1;
        tick();
        tick();
        check_out("reset", 1'b0, 5'd0);
        check_bad("reset", 1'b0, 32'h0);
        reset = 1'b0;

        // ---------------- vector table (acknowledge held) ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            idle();
            bus.exc_ack     = 1'b1;
            bus.req_valid   = vecs[i].valid;
            bus.req_addr    = vecs[i].addr;
            bus.req_size    = vecs[i].size;
            bus.req_store   = vecs[i].store;
            bus.exc_in      = vecs[i].exc_in;
            bus.exc_code_in = vecs[i].code_in;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].exp_exc, vecs[i].exp_code);
            check($sformatf("vec%0d.pend", i), 32'(bus.bad_pend), 32'(vecs[i].exp_local));
            if (vecs[i].exp_local)
                check($sformatf("vec%0d.vaddr", i), bus.bad_vaddr, vecs[i].addr);
        end

        idle();
        bus.exc_ack = 1'b1;
        tick();
        check("clear.pend", 32'(bus.bad_pend), 32'h0);

        // ---------------- sticky BadVAddr ----------------
        idle(); req(32'h0000_2FFC, SIZE_WORD, 0); tick();
        check_out("lw2ffc", 1'b0, 5'd0);
        check("lw2ffc.pend", 32'(bus.bad_pend), 32'h0);
        idle(); req(32'h0000_2FFE, SIZE_WORD, 0); tick();
        check_out("lw2ffe", 1'b1, 5'd4);
        check_bad("lw2ffe", 1'b1, 32'h0000_2FFE);
        idle(); req(32'h0000_3000, SIZE_WORD, 0); tick();
        check_out("second", 1'b1, 5'd4);
        check_bad("second", 1'b1, 32'h0000_2FFE);
        idle(); req(32'h0000_3004, SIZE_WORD, 1); bus.exc_ack = 1'b1; tick();
        check_out("ackfault", 1'b1, 5'd5);
        check_bad("ackfault", 1'b1, 32'h0000_3004);
        idle(); bus.exc_ack = 1'b1; tick();
        check_out("ackonly", 1'b0, 5'd0);
        check_bad("ackonly", 1'b0, 32'h0000_3004);

        // ---------------- upstream exception, stall and flush ----------------
        idle(); req(32'h0000_3000, SIZE_WORD, 0);
        bus.exc_in = 1'b1; bus.exc_code_in = 5'd12; tick();
        check_out("excin", 1'b1, 5'd12);
        check("excin.pend", 32'(bus.bad_pend), 32'h0);
        idle(); bus.stall = 1'b1; tick();
        check_out("stall_idle", 1'b1, 5'd12);
        idle(); req(32'h0000_3008, SIZE_WORD, 0); bus.stall = 1'b1; tick();
        check_out("stall_fault", 1'b1, 5'd12);
        check("stall_fault.pend", 32'(bus.bad_pend), 32'h0);
        idle(); req(32'h0000_3008, SIZE_WORD, 0); bus.flush = 1'b1; tick();
        check_out("flush", 1'b0, 5'd0);
        check("flush.pend", 32'(bus.bad_pend), 32'h0);
        idle(); req(32'h0000_3008, SIZE_WORD, 1); tick();
        check_out("after_flush", 1'b1, 5'd5);
        idle(); req(32'h0000_2FFC, SIZE_WORD, 0);
        bus.stall = 1'b1; bus.flush = 1'b1; tick();
        check_out("stall_over_flush", 1'b1, 5'd5);
        check_bad("stall_over_flush", 1'b1, 32'h0000_3008);
        idle(); bus.exc_ack = 1'b1; tick();
        check("ack2.pend", 32'(bus.bad_pend), 32'h0);

        // ---------------- config write timing ----------------
        idle(); req(32'h0000_1000, SIZE_WORD, 0);
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_base = 32'h0;
        bus.cfg_limit = 32'h0000_0FFF; bus.cfg_perm = 3'b111; tick();
        check_out("cfg_same", 1'b0, 5'd0);
        idle(); req(32'h0000_1000, SIZE_WORD, 0); tick();
        check_out("cfg_next", 1'b1, 5'd4);
        check_bad("cfg_next", 1'b1, 32'h0000_1000);
        idle(); bus.cfg_we = 1'b1; bus.cfg_idx = 3'd6; bus.cfg_base = 32'h0000_1000;
        bus.cfg_limit = 32'h0000_1FFF; bus.cfg_perm = 3'b111; tick();
        idle(); req(32'h0000_1000, SIZE_WORD, 0); tick();
        check_out("cfg_idx6", 1'b1, 5'd4);

`ifdef MAC_ADDR_OVF_EN
        idle(); req(32'h0000_7F20, SIZE_BYTE, 1); bus.addr_ovf = 1'b1;
        bus.exc_ack = 1'b1; tick();
        check_out("ovf", 1'b1, 5'd5);
        check_bad("ovf", 1'b1, 32'h0000_7F20);
`endif

        // ---------------- asynchronous reset mid-run ----------------
        idle();
        reset = 1'b1;
        #2;
        check_out("midreset", 1'b0, 5'd0);
        check_bad("midreset", 1'b0, 32'h0);
        tick();
        reset = 1'b0;
        idle(); req(32'h0000_1000, SIZE_WORD, 0); tick();
        check_out("table_restored", 1'b0, 5'd0);
        idle(); req(32'h0000_7F08, SIZE_WORD, 1); tick();
        check_out("r2_restored", 1'b1, 5'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
